glb_core_pc_router_mc: RTL

- Parametrised successor of the GLB tile parallel-configuration (PC) read-packet router.
- Carries NUM_CH independent PC channels between the core switch and the west/east neighbouring tiles.
- Each channel keeps the even/odd tile role and the chain-end turn-around behaviour. New in this block: a configurable hop pipeline depth, per-channel enables with flush, and per-channel injected-packet counters.

---
 rtl/glb_core_pc_router_mc.sv | 121 ++++++++++++
 1 files changed

// File: rtl/glb_core_pc_router_mc.sv
// Multi-channel GLB tile parallel-configuration read-packet router.
// Each channel routes packets between core switch and west/east neighbours with a PIPE_DEPTH hop pipeline.
module glb_core_pc_router_mc #(
   parameter int NUM_CH     = 2,
   parameter int PKT_W      = 64,
   parameter int PIPE_DEPTH = 1,
   parameter int TILE_ID_W  = 5,
   parameter int CNT_W      = 16
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic [TILE_ID_W-1:0]    glb_tile_id,
   input  logic [NUM_CH-1:0]       w2e_wsti_vld,
   input  logic [NUM_CH*PKT_W-1:0] w2e_wsti_data,
   output logic [NUM_CH-1:0]       e2w_wsto_vld,
   output logic [NUM_CH*PKT_W-1:0] e2w_wsto_data,
   input  logic [NUM_CH-1:0]       e2w_esti_vld,
   input  logic [NUM_CH*PKT_W-1:0] e2w_esti_data,
   output logic [NUM_CH-1:0]       w2e_esto_vld,
   output logic [NUM_CH*PKT_W-1:0] w2e_esto_data,
   input  logic [NUM_CH-1:0]       sw2pcr_vld,
   input  logic [NUM_CH*PKT_W-1:0] sw2pcr_data,
   output logic [NUM_CH-1:0]       pcr2sw_vld,
   output logic [NUM_CH*PKT_W-1:0] pcr2sw_data,
   input  logic [NUM_CH-1:0]       cfg_pc_tile_connected_prev,
   input  logic [NUM_CH-1:0]       cfg_pc_tile_connected_next,
   input  logic [NUM_CH-1:0]       cfg_pc_ch_en,
   input  logic                    cfg_cnt_clear,
   output logic [NUM_CH*CNT_W-1:0] pc_pkt_cnt
);

   localparam int LN_SW = 0;
   localparam int LN_W  = 1;
   localparam int LN_E  = 2;

   logic tile_odd;
   logic tile_id_unused;

   assign tile_odd       = glb_tile_id[0];
   assign tile_id_unused = ^glb_tile_id;

   for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
      localparam int LSB = gi * PKT_W;

      logic             ch_en;
      logic             wsto_vld, esto_vld, pcr_vld;
      logic [PKT_W-1:0] wsto_data, esto_data, pcr_data;
      logic             wsti_t_vld, esti_t_vld;
      logic [PKT_W-1:0] wsti_t_data, esti_t_data;
      logic             line_vld  [3];
      logic [PKT_W-1:0] line_data [3];
      logic             stg_vld   [3][PIPE_DEPTH];
      logic [PKT_W-1:0] stg_data  [3][PIPE_DEPTH];
      logic [CNT_W-1:0] cnt_reg;

      assign ch_en = cfg_pc_ch_en[gi];

      // At an unconnected chain end the tile's own outgoing packet turns back in.
      assign wsti_t_vld  = cfg_pc_tile_connected_prev[gi] ? w2e_wsti_vld[gi] : wsto_vld;
      assign wsti_t_data = cfg_pc_tile_connected_prev[gi] ? w2e_wsti_data[LSB +: PKT_W] : wsto_data;
      assign esti_t_vld  = cfg_pc_tile_connected_next[gi] ? e2w_esti_vld[gi] : esto_vld;
      assign esti_t_data = cfg_pc_tile_connected_next[gi] ? e2w_esti_data[LSB +: PKT_W] : esto_data;

      assign line_vld[LN_SW]  = sw2pcr_vld[gi];
      assign line_data[LN_SW] = sw2pcr_data[LSB +: PKT_W];
      assign line_vld[LN_W]   = wsti_t_vld;
      assign line_data[LN_W]  = wsti_t_data;
      assign line_vld[LN_E]   = esti_t_vld;
      assign line_data[LN_E]  = esti_t_data;

      always_ff @(posedge clk or posedge reset) begin
         if (reset || !ch_en) begin
            for (int l = 0; l < 3; l++) begin
               for (int s = 0; s < PIPE_DEPTH; s++) begin
                  stg_vld[l][s]  <= 1'b0;
                  stg_data[l][s] <= '0;
               end
            end
         end else begin
            for (int l = 0; l < 3; l++) begin
               stg_vld[l][0]  <= line_vld[l];
               stg_data[l][0] <= line_vld[l] ? line_data[l] : '0;
               for (int s = 1; s < PIPE_DEPTH; s++) begin
                  stg_vld[l][s]  <= stg_vld[l][s-1];
                  stg_data[l][s] <= stg_data[l][s-1];
               end
            end
         end
      end

      // Tile parity decides which delay line feeds each neighbour and which turned input the switch sees.
      assign esto_vld  = ch_en & (tile_odd ? stg_vld[LN_W][PIPE_DEPTH-1] : stg_vld[LN_SW][PIPE_DEPTH-1]);
      assign esto_data = !ch_en ? '0 :
                         (tile_odd ? stg_data[LN_W][PIPE_DEPTH-1] : stg_data[LN_SW][PIPE_DEPTH-1]);
      assign wsto_vld  = ch_en & (tile_odd ? stg_vld[LN_SW][PIPE_DEPTH-1] : stg_vld[LN_E][PIPE_DEPTH-1]);
      assign wsto_data = !ch_en ? '0 :
                         (tile_odd ? stg_data[LN_SW][PIPE_DEPTH-1] : stg_data[LN_E][PIPE_DEPTH-1]);
      assign pcr_vld   = ch_en & (tile_odd ? esti_t_vld : wsti_t_vld);
      assign pcr_data  = !ch_en ? '0 : (tile_odd ? esti_t_data : wsti_t_data);

      assign w2e_esto_vld[gi]               = esto_vld;
      assign w2e_esto_data[LSB +: PKT_W]    = esto_data;
      assign e2w_wsto_vld[gi]               = wsto_vld;
      assign e2w_wsto_data[LSB +: PKT_W]    = wsto_data;
      assign pcr2sw_vld[gi]                 = pcr_vld;
      assign pcr2sw_data[LSB +: PKT_W]      = pcr_data;

      always_ff @(posedge clk or posedge reset) begin
         if (reset) begin
            cnt_reg <= '0;
         end else if (cfg_cnt_clear) begin
            cnt_reg <= '0;
         end else if (sw2pcr_vld[gi] && ch_en && (cnt_reg != {CNT_W{1'b1}})) begin
            cnt_reg <= cnt_reg + CNT_W'(1);
         end
      end

      assign pc_pkt_cnt[gi*CNT_W +: CNT_W] = cnt_reg;
   end

endmodule
